// File: rtl/div_mod_arbiter_if.sv
// Requester-side bus of div_mod_arbiter: request/accept and response/acknowledge
// channels for NUM_REQ requesters sharing one divider.
interface div_mod_arbiter_if #(
    parameter int NUM_REQ = 4
);
    // Request: a requester raises req_valid with operands and holds them until its
    // req_ready pulse. Response: resp_valid stays high until the owner's resp_ready.
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_mode;
    logic [32*NUM_REQ-1:0] req_dividend;
    logic [16*NUM_REQ-1:0] req_divisor;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [NUM_REQ-1:0]    resp_ready;
    logic [31:0]           resp_result;
    logic                  resp_err;

    modport slave (
        input  req_valid, req_mode, req_dividend, req_divisor, resp_ready,
        output req_ready, resp_valid, resp_result, resp_err
    );

    modport master (
        output req_valid, req_mode, req_dividend, req_divisor, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_err
    );
endinterface

// File: rtl/div_mod_arbiter.sv
// Round-robin front end for a shared 5-stage divider: screens overflow operands,
// keeps one operation in flight with operands held, routes the result back.
module div_mod_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 5,
    parameter int TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                reset,
    div_mod_arbiter_if.slave    req_bus,
    output logic                div_valid_in,
    output logic                div_mode,
    output logic [31:0]         div_dividend,
    output logic [15:0]         div_divisor,
    input  logic [31:0]         div_result,
    input  logic                div_valid_out,
    output logic [1:0]          state_dbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    // A timeout at or below the divider latency would abort every operation.
    localparam int CNT_MAX = (TIMEOUT > LATENCY) ? TIMEOUT : LATENCY + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr, grant, pick;
    logic               pick_found;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               hold_mode;
    logic [31:0]        hold_dividend;
    logic [15:0]        hold_divisor;
    logic [31:0]        pick_dividend;
    logic [15:0]        pick_divisor;
    logic               overflow;
    logic               accept;
    logic               load_result;
    logic [31:0]        result_nxt, result_q;
    logic               err_nxt, err_q;

    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!pick_found && req_bus.req_valid[idx]) begin
                pick_found = 1'b1;
                pick       = IDX_W'(idx);
            end
        end
    end

    assign pick_dividend = req_bus.req_dividend[32*pick +: 32];
    assign pick_divisor  = req_bus.req_divisor[16*pick +: 16];
    // Quotient needs more than 17 bits (or divisor is zero) exactly when this holds.
    assign overflow      = {1'b0, pick_dividend[31:17]} >= pick_divisor;

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        load_result = 1'b0;
        result_nxt  = '0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    accept      = 1'b1;
                    load_result = overflow;
                    result_nxt  = 32'hFFFF_FFFF;
                    err_nxt     = 1'b1;
                    state_nxt   = overflow ? DONE : ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (div_valid_out) begin
                    load_result = 1'b1;
                    result_nxt  = div_result;
                    err_nxt     = 1'b0;
                    state_nxt   = DONE;
                end else if (tmo_cnt == CNT_W'(CNT_MAX - 1)) begin
                    load_result = 1'b1;
                    result_nxt  = '0;
                    err_nxt     = 1'b1;
                    state_nxt   = DONE;
                end
            end
            DONE: begin
                if (req_bus.resp_ready[grant]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant         <= '0;
            tmo_cnt       <= '0;
            hold_mode     <= 1'b0;
            hold_dividend <= '0;
            hold_divisor  <= '0;
            result_q      <= '0;
            err_q         <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                grant         <= pick;
                rr_ptr        <= IDX_W'((int'(pick) + 1) % NUM_REQ);
                hold_mode     <= req_bus.req_mode[pick];
                hold_dividend <= pick_dividend;
                hold_divisor  <= pick_divisor;
            end
            if (state == ISSUE) tmo_cnt <= '0;
            else if (state == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
            if (load_result) begin
                result_q <= result_nxt;
                err_q    <= err_nxt;
            end
        end
    end

    // Later divider rows read these directly, so they may only move on an accept.
    assign div_valid_in         = (state == ISSUE);
    assign div_mode             = hold_mode;
    assign div_dividend         = hold_dividend;
    assign div_divisor          = hold_divisor;
    assign req_bus.req_ready    = accept ? (NUM_REQ'(1) << pick) : '0;
    assign req_bus.resp_valid   = (state == DONE) ? (NUM_REQ'(1) << grant) : '0;
    assign req_bus.resp_result  = result_q;
    assign req_bus.resp_err     = err_q;
    assign state_dbg            = state;
endmodule

// File: tb/tb_div_mod_arbiter.sv
// Bench for div_mod_arbiter: behavioural divider, round-robin/arith reference model,
// response scoreboard, directed cases followed by random traffic.
module tb_div_mod_arbiter;
  localparam int NUM_REQ = 4;
  localparam int LATENCY = 5;
  localparam int TIMEOUT = 8;
  localparam int W       = 56;  // {resp cycle[19:0], id[2:0], err, result[31:0]}

  logic        clk = 1'b0;
  logic        reset;
  logic        div_valid_in, div_mode, div_valid_out;
  logic [31:0] div_dividend, div_result;
  logic [15:0] div_divisor;
  logic [1:0]  state_dbg;

  div_mod_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  div_mod_arbiter #(.NUM_REQ(NUM_REQ), .LATENCY(LATENCY), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_bus(bus.slave),
    .div_valid_in(div_valid_in), .div_mode(div_mode), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_result(div_result), .div_valid_out(div_valid_out),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0, errors = 0;
  int rr_ptr_m = 0;
  bit busy = 0;
  int free_cyc = 0;
  logic [NUM_REQ-1:0] pend_clear = '0;
  int issue_exp = -1, resp_exp = -1;
  bit track = 0;
  logic h_mode;
  logic [31:0] h_dvd;
  logic [15:0] h_dvs;
  int ret_cyc = -1;
  bit div_dead = 0, stray_req = 0;
  bit resp_seen = 0;
  int ack_wait = 0, owner = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int p);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    return 0;
  endfunction

  // Expected response for an accept at cycle t, from the arithmetic rules.
  function automatic logic [W-1:0] model(input int id, input logic mode, input logic [31:0] dvd,
                                         input logic [15:0] dvs, input int t, input bit dead);
    logic [31:0] res;
    logic        err;
    int          tr;
    if (dvs == 16'd0 || (dvd / {16'd0, dvs}) >= 32'h0002_0000) begin
      res = 32'hFFFF_FFFF; err = 1'b1; tr = t + 1;
    end else if (dead) begin
      res = 32'd0; err = 1'b1; tr = t + 2 + TIMEOUT;
    end else begin
      res = mode ? dvd % {16'd0, dvs} : dvd / {16'd0, dvs}; err = 1'b0; tr = t + 2 + LATENCY;
    end
    return {20'(tr), 3'(id), err, res};
  endfunction

  // ---------------- accept monitor + divider model ----------------
  initial begin
    int g;
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (reset) continue;
      bus.req_valid = bus.req_valid & ~pend_clear;
      pend_clear = '0;
      if (busy && cyc >= free_cyc) busy = 0;
      if (!busy && bus.req_valid != '0) begin
        g = rr_pick(bus.req_valid, rr_ptr_m);
        check("grant", 32'(bus.req_ready), 32'(1) << g);
        e = model(g, bus.req_mode[g], bus.req_dividend[32*g +: 32], bus.req_divisor[16*g +: 16],
                  cyc, div_dead);
        exp_q.push_back(e);
        resp_exp  = int'(e[55:36]);
        issue_exp = (resp_exp == cyc + 1) ? -1 : cyc + 1;
        h_mode = bus.req_mode[g];
        h_dvd  = bus.req_dividend[32*g +: 32];
        h_dvs  = bus.req_divisor[16*g +: 16];
        track = 1; busy = 1; free_cyc = 32'h7FFF_FFFF;
        rr_ptr_m = (g + 1) % NUM_REQ;
        pend_clear[g] = 1'b1;
      end else if (bus.req_ready != '0) begin
        check("spurious_grant", 32'(bus.req_ready), 32'd0);
      end
      if (div_valid_in || cyc == issue_exp)
        check("div_valid_in", 32'(div_valid_in), 32'(cyc == issue_exp));
      if (track && issue_exp >= 0 && cyc >= issue_exp && cyc <= resp_exp) begin
        check("hold_dividend", div_dividend, h_dvd);
        check("hold_divisor", 32'(div_divisor), 32'(h_dvs));
        check("hold_mode", 32'(div_mode), 32'(h_mode));
      end
      if (cyc > resp_exp) track = 0;
      if (div_valid_in && !div_dead) ret_cyc = cyc + LATENCY;
      if (cyc == ret_cyc) begin
        div_valid_out = 1'b1;
        if (div_divisor == 16'd0) div_result = 32'hFFFF_FFFF;
        else div_result = div_mode ? div_dividend % {16'd0, div_divisor}
                                   : div_dividend / {16'd0, div_divisor};
      end else if (stray_req) begin
        div_valid_out = 1'b1;
        div_result = $urandom;
        stray_req = 0;
      end else begin
        div_valid_out = 1'b0;
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    logic [W-1:0] e;
    logic [NUM_REQ-1:0] junk, own;
    forever begin
      @(negedge clk);
      if (reset) continue;
      junk = NUM_REQ'($urandom);
      if (bus.resp_valid != '0) begin
        if (!resp_seen) begin
          if (exp_q.size() == 0) begin
            check("resp_unexpected", 32'(bus.resp_valid), 32'd0);
            owner = 0;
            for (int i = NUM_REQ - 1; i >= 0; i--) if (bus.resp_valid[i]) owner = i;
          end else begin
            e = exp_q.pop_front();
            owner = int'(e[35:33]);
            check("resp_onehot", 32'(bus.resp_valid), 32'(1) << owner);
            check("resp_result", bus.resp_result, e[31:0]);
            check("resp_err", 32'(bus.resp_err), 32'(e[32]));
            check("resp_cycle", cyc, 32'(e[55:36]));
          end
          resp_seen = 1;
          ack_wait = $urandom_range(0, 2);
        end
        own = NUM_REQ'(1) << owner;
        if (ack_wait == 0) begin
          bus.resp_ready = junk | own;
          free_cyc = cyc + 1;
          resp_seen = 0;
        end else begin
          ack_wait--;
          bus.resp_ready = junk & ~own;
        end
      end else begin
        if (resp_seen) begin
          check("resp_held", 32'(bus.resp_valid), 32'(1) << owner);
          resp_seen = 0;
        end
        bus.resp_ready = '0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int id, input logic mode, input logic [31:0] dvd, input logic [15:0] dvs);
    bus.req_mode[id] = mode;
    bus.req_dividend[32*id +: 32] = dvd;
    bus.req_divisor[16*id +: 16] = dvs;
    bus.req_valid[id] = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && !busy && bus.req_valid == '0 && !resp_seen) && n < 300);
    check("idle_wait", 32'(n < 300), 32'd1);
  endtask

  task automatic wait_accept();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < 50);
    check("accept_wait", 32'(busy), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, "_div_valid_in"}, 32'(div_valid_in), 32'd0);
    check({tag, "_div_dividend"}, div_dividend, 32'd0);
    check({tag, "_div_divisor"}, 32'(div_divisor), 32'd0);
    check({tag, "_div_mode"}, 32'(div_mode), 32'd0);
    check({tag, "_resp_result"}, bus.resp_result, 32'd0);
    check({tag, "_resp_err"}, 32'(bus.resp_err), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  task automatic flush();
    exp_q.delete();
    busy = 0; rr_ptr_m = 0; pend_clear = '0;
    issue_exp = -1; resp_exp = -1; track = 0;
    ret_cyc = -1; stray_req = 0; resp_seen = 0;
    bus.req_valid = '0; bus.resp_ready = '0;
    div_valid_out = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [NUM_REQ-1:0] m;
    logic [31:0] dvd;
    logic [15:0] dvs;
    bus.req_valid = '0; bus.req_mode = '0; bus.req_dividend = '0; bus.req_divisor = '0;
    bus.resp_ready = '0; div_valid_out = 1'b0; div_result = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    reset = 1'b0;

    // single request, quotient then remainder
    step(); set_req(0, 1'b0, 32'd100, 16'd7); wait_idle();
    step(); set_req(0, 1'b1, 32'd100, 16'd7); wait_idle();

    // operands change after accept; divider must still see 100/7
    step(); set_req(0, 1'b0, 32'd100, 16'd7); wait_accept();
    repeat (2) @(posedge clk);
    #1 bus.req_dividend[31:0] = 32'd555; bus.req_divisor[15:0] = 16'd3;
    wait_idle();

    // round robin: req3 alone brings the pointer back to 0
    step(); set_req(3, 1'b0, 32'd1000, 16'd10); wait_idle();
    step(); set_req(0, 1'b0, 32'd81, 16'd9); set_req(2, 1'b1, 32'd82, 16'd9); wait_idle();
    step(); set_req(0, 1'b1, 32'd1234, 16'd11); set_req(1, 1'b0, 32'd99999, 16'd77);
    set_req(3, 1'b0, 32'd65535, 16'd256); wait_idle();

    // operand screen
    step(); set_req(1, 1'b0, 32'd1234, 16'd0); wait_idle();
    step(); set_req(2, 1'b0, 32'h0004_0000, 16'd2); wait_idle();
    step(); set_req(2, 1'b0, 32'h0003_FFFF, 16'd2); wait_idle();

    // timeout, then a stray divider pulse while idle
    div_dead = 1;
    step(); set_req(1, 1'b0, 32'd5000, 16'd3); wait_idle();
    div_dead = 0;
    step(); stray_req = 1;
    repeat (4) @(posedge clk);
    step(); set_req(3, 1'b1, 32'd77777, 16'd100); wait_idle();

    // reset in the middle of WAIT
    step(); set_req(0, 1'b0, 32'd100, 16'd7); wait_accept();
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("midreset");
    flush();
    step(); reset = 1'b0;
    step(); set_req(1, 1'b0, 32'd300, 16'd4); set_req(0, 1'b1, 32'd301, 16'd4); wait_idle();

    // random traffic
    for (int it = 0; it < 40; it++) begin
      m = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      step();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (m[i]) begin
          case ($urandom_range(0, 3))
            0: begin dvd = $urandom; dvs = 16'd0; end
            1: begin dvd = $urandom; dvs = 16'($urandom_range(1, 65535)); end
            2: begin dvd = 32'($urandom_range(0, 100000)); dvs = 16'($urandom_range(1, 300)); end
            default: begin dvd = $urandom; dvs = 16'($urandom_range(1, 4)); end
          endcase
          set_req(i, 1'($urandom), dvd, dvs);
        end
      end
      wait_idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
